// File: rtl/sound_pkg.sv
// Shared constants and the frame-word builder for the I2S transmit path.
// Samples are left-justified inside each channel slot and zero-padded below.
package sound_pkg;

    localparam int I2S_SLOT_BITS_DEFAULT = 32;
    localparam int I2S_BCLK_DIV_DEFAULT  = 4;
    localparam int I2S_MAX_SLOT_BITS     = 64;

    typedef logic [I2S_MAX_SLOT_BITS-1:0]   i2s_slot_t;
    typedef logic [2*I2S_MAX_SLOT_BITS-1:0] i2s_frame_t;

    // Result sits in the low 2*slot_bits bits: {l, pad, r, pad}. No sign extension.
    function automatic i2s_frame_t i2s_frame_word(
        input i2s_slot_t l,
        input i2s_slot_t r,
        input int        in_width,
        input int        slot_bits
    );
        i2s_slot_t  mask;
        i2s_frame_t w;
        mask = (i2s_slot_t'(1) << in_width) - i2s_slot_t'(1);
        w = (i2s_frame_t'(l & mask) << (2*slot_bits - in_width))
          | (i2s_frame_t'(r & mask) << (slot_bits - in_width));
        return w;
    endfunction

endpackage

// File: rtl/sound_i2s_clkgen.sv
// BCLK generator: divides the system clock and flags the cycle in which
// BCLK is about to be driven low, which is when all serial outputs advance.
module sound_i2s_clkgen
    import sound_pkg::*;
#(
    parameter int BCLK_DIV = I2S_BCLK_DIV_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    output logic bclk,
    output logic fall_evt
);

    localparam int            CW   = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
    localparam logic [CW-1:0] TERM = CW'(BCLK_DIV - 1);

    if (BCLK_DIV < 1) begin : g_bad_div
        $error("sound_i2s_clkgen: BCLK_DIV must be >= 1");
    end

    logic [CW-1:0] cnt;
    logic          term;

    assign term     = (cnt == TERM);
    assign fall_evt = term & bclk;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt  <= '0;
            bclk <= 1'b0;
        end else if (term) begin
            cnt  <= '0;
            bclk <= ~bclk;
        end else begin
            cnt  <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/sound_i2s_tx.sv
// I2S bus-master transmitter: one stereo frame of 2*SLOT_BITS bit clocks,
// data delayed one BCLK after each LRCK transition, MSB first.
module sound_i2s_tx
    import sound_pkg::*;
#(
    parameter int IN_WIDTH  = 16,
    parameter int SLOT_BITS = I2S_SLOT_BITS_DEFAULT,
    parameter int BCLK_DIV  = I2S_BCLK_DIV_DEFAULT
) (
    input  logic                CLK,
    input  logic                RESET,
    input  logic [IN_WIDTH-1:0] IN_L,
    input  logic [IN_WIDTH-1:0] IN_R,
    input  logic                MUTE,
    output logic                BCLK,
    output logic                LRCK,
    output logic                SDATA,
    output logic                SAMPLE_REQ
);

    localparam int            FW      = 2 * SLOT_BITS;
    localparam int            BW      = $clog2(FW);
    localparam logic [BW-1:0] B_LAST  = BW'(FW - 1);
    localparam logic [BW-1:0] B_LOAD  = BW'(1);
    localparam logic [BW-1:0] B_RIGHT = BW'(SLOT_BITS);

    if (IN_WIDTH < 1 || IN_WIDTH > SLOT_BITS) begin : g_bad_width
        $error("sound_i2s_tx: IN_WIDTH must be in 1..SLOT_BITS");
    end
    if (SLOT_BITS > I2S_MAX_SLOT_BITS) begin : g_bad_slot
        $error("sound_i2s_tx: SLOT_BITS exceeds I2S_MAX_SLOT_BITS");
    end

    logic          fall_evt;
    logic [BW-1:0] bit_idx;
    logic [BW-1:0] bit_idx_nxt;
    logic [FW-1:0] shreg;
    logic [FW-1:0] frame;

    sound_i2s_clkgen #(
        .BCLK_DIV (BCLK_DIV)
    ) u_clkgen (
        .clk      (CLK),
        .rst      (RESET),
        .bclk     (BCLK),
        .fall_evt (fall_evt)
    );

    // SAMPLE_REQ is a strobe with no back-pressure: IN_L/IN_R/MUTE are taken
    // in the SAMPLE_REQ-raising cycle, so the producer must hold them valid then.
    always_comb begin
        bit_idx_nxt = (bit_idx == B_LAST) ? '0 : bit_idx + 1'b1;
        frame       = MUTE ? '0
                           : FW'(i2s_frame_word(i2s_slot_t'(IN_L), i2s_slot_t'(IN_R),
                                                IN_WIDTH, SLOT_BITS));
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            bit_idx    <= '0;
            LRCK       <= 1'b0;
            SDATA      <= 1'b0;
            SAMPLE_REQ <= 1'b0;
            shreg      <= '0;
        end else begin
            SAMPLE_REQ <= 1'b0;
            if (fall_evt) begin
                bit_idx <= bit_idx_nxt;
                LRCK    <= (bit_idx_nxt >= B_RIGHT);
                // Loading at b==1 yields the one-BCLK I2S delay; the previous
                // right LSB has just gone out at b==0.
                if (bit_idx_nxt == B_LOAD) begin
                    SDATA      <= frame[FW-1];
                    shreg      <= frame << 1;
                    SAMPLE_REQ <= 1'b1;
                end else begin
                    SDATA <= shreg[FW-1];
                    shreg <= shreg << 1;
                end
            end
        end
    end

endmodule

// File: doc/sound_i2s_tx.md
Name: sound_i2s_tx

Overview:
- Serialises the final stereo mix into an I2S stream for an external audio DAC.
- Sits downstream of the mixer and attenuator chain. It is the consumer at the other end of the sound signal path.
- Generates BCLK and LRCK itself as bus master from the system clock.
- Latches one left/right sample pair per frame and pulses a sample-request strobe.

Parameters:
- IN_WIDTH, 16, width of the signed two's-complement input samples; must be <= SLOT_BITS.
- SLOT_BITS, 32, BCLK cycles per channel slot; frame = 2*SLOT_BITS BCLK cycles.
- BCLK_DIV, 4, CLK cycles per BCLK half-period; must be >= 1.

Ports:
- CLK  in  1  system clock.
- RESET  in  1  asynchronous, active-high reset.
- IN_L  in  IN_WIDTH  left sample, signed.
- IN_R  in  IN_WIDTH  right sample, signed.
- MUTE  in  1  when high at load time, a zero frame is transmitted.
- BCLK  out  1  I2S bit clock.
- LRCK  out  1  I2S word select; 0 = left, 1 = right.
- SDATA  out  1  I2S serial data, MSB first.
- SAMPLE_REQ  out  1  one-CLK pulse when IN_L/IN_R are captured.

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-frame):
  - BCLK=0, LRCK=0, SDATA=0, SAMPLE_REQ=0.
  - Divider counter=0, bit index b=0, shift register=0.
- Divider:
  - Counter runs 0..BCLK_DIV-1. At the terminal count it wraps and BCLK toggles.
  - BCLK period = 2*BCLK_DIV CLK cycles.
  - First BCLK rise occurs BCLK_DIV cycles after reset release; first fall occurs 2*BCLK_DIV cycles after release.
- Falling-edge event (the CLK cycle in which BCLK is driven 1->0):
  - b <= (b+1) mod 2*SLOT_BITS.
  - LRCK <= (new b >= SLOT_BITS).
  - SDATA and the shift register update per the load/shift rules below.
  - All outputs are registered. Nothing changes on rising edges except BCLK itself.
- Frame word: W = {IN_L, zeros(SLOT_BITS-IN_WIDTH), IN_R, zeros(SLOT_BITS-IN_WIDTH)}, 2*SLOT_BITS bits.
  - Narrow samples are left-justified and zero-padded in the LSBs.
  - No sign extension and no truncation.
- Load (falling edge where new b == 1):
  - If MUTE=1, W is replaced by all zeros.
  - SDATA <= W[MSB]; shift register <= W << 1.
  - SAMPLE_REQ=1 in that same CLK cycle only.
- Shift (every other falling edge):
  - SDATA <= shift register MSB; shift register <<= 1 with zero fill.
- Resulting timing:
  - Word bit k (k=0 is the MSB) is driven at b=(k+1) mod 2*SLOT_BITS. This is the standard I2S one-BCLK delay after each LRCK transition.
  - The right LSB goes out at b=0 of the following frame.
- Sample capture:
  - IN_L, IN_R and MUTE are sampled only at load. Changes between loads have no effect.
  - SAMPLE_REQ period = 4*SLOT_BITS*BCLK_DIV CLK cycles.
- First frame after reset: SDATA at b=0 is 0, since there is no previous right LSB.
- External timing: the DAC samples SDATA on BCLK rising. SDATA and LRCK are stable for BCLK_DIV CLK cycles before each rise.
- Parameter violations (IN_WIDTH > SLOT_BITS, or BCLK_DIV < 1) are elaboration errors.

Decomposition:
- Package sound_pkg holds:
  - I2S_SLOT_BITS_DEFAULT and I2S_BCLK_DIV_DEFAULT constants.
  - A function building the left-justified, zero-padded frame word.
- One sub-module, sound_i2s_clkgen:
  - Contains the divider counter and the BCLK register.
  - Outputs BCLK plus a one-cycle fall_evt strobe. rise_evt is for the bench only.
- The top module holds the bit index, LRCK, the shift register, SDATA and SAMPLE_REQ.

Test Plan:
- Reset timing (IN_WIDTH=16, SLOT_BITS=16, BCLK_DIV=2): assert RESET mid-frame with SDATA=1 -> all outputs 0 in the same cycle. After release: BCLK rises at cycle 2 and falls at cycle 4; SAMPLE_REQ pulses at cycle 4; LRCK=0.
- Stereo bit pattern (same params): IN_L=16'hA5C3, IN_R=16'h0001. Sample SDATA on BCLK rises -> expect:
  - LRCK=0 slot: leading 0 (first frame), then 1010_0101_1100_001.
  - LRCK=1 slot: the left LSB 1, then 15 zeros.
  - Next frame's b=0 bit: 1.
- Narrow input (IN_WIDTH=10, SLOT_BITS=16): IN_L=10'h200, IN_R=10'h3FF -> left word 16'h8000; right word 16'hFFC0.
- Capture isolation: change IN_L from 16'h1234 to 16'hFFFF at b=5 -> the current frame still carries 16'h1234; the next frame carries 16'hFFFF. SAMPLE_REQ spacing is exactly 128 CLK cycles.
- MUTE: MUTE=1 at load with IN_L=IN_R=16'h7FFF -> all-zero frame. MUTE pulsed high mid-frame -> the frame is unaffected.
- BCLK_DIV=1: BCLK toggles every CLK; LRCK period = 64 CLK cycles (SLOT_BITS=16); the bit pattern matches the stereo bit pattern scenario.
